// File: rtl/br_fifo_shared_linked_list_head_ctrl_pkg.sv
// Shared helpers for the linked-list head controller: width math and the
// head-pointer update selector used by every per-FIFO slice.
package br_fifo_shared_linked_list_head_ctrl_pkg;

    typedef enum logic [1:0] {
        HEAD_HOLD      = 2'd0,
        HEAD_LOAD_PUSH = 2'd1,
        HEAD_ADVANCE   = 2'd2
    } head_sel_e;

    function automatic int clamped_clog2(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // A push into an empty list, or into a list whose only entry is leaving, becomes the head.
    function automatic head_sel_e head_select(input logic push, input logic pop,
                                              input logic cnt_zero, input logic cnt_one);
        if (push && (cnt_zero || (pop && cnt_one))) begin
            return HEAD_LOAD_PUSH;
        end else if (pop && !cnt_one) begin
            return HEAD_ADVANCE;
        end else begin
            return HEAD_HOLD;
        end
    endfunction

endpackage

// File: rtl/br_fifo_shared_linked_list_head_ctrl_chk.sv
// Implementation and integration checks for the linked-list head controller.
module br_fifo_shared_linked_list_head_ctrl_chk #(
    parameter int NumFifos    = 1,
    parameter int Depth       = 2,
    parameter int AddrWidth   = 1,
    parameter int CountWidth  = 2,
    parameter int FifoIdWidth = 1
) (
    input logic                                  clk,
    input logic                                  rst,
    input logic                                  push_valid,
    input logic [FifoIdWidth-1:0]                push_fifo_id,
    input logic [NumFifos-1:0]                   head_valid,
    input logic [NumFifos-1:0]                   head_ready,
    input logic [NumFifos-1:0][AddrWidth-1:0]    head,
    input logic [NumFifos-1:0]                   ram_empty,
    input logic [NumFifos-1:0][CountWidth-1:0]   ram_items
);

    for (genvar i = 0; i < NumFifos; i++) begin : g_chk
        a_head_stable: assert property (@(posedge clk) disable iff (rst)
            (!rst && head_valid[i] && !head_ready[i]) |=> (head_valid[i] && $stable(head[i])));
        a_no_wrap: assert property (@(posedge clk) disable iff (rst)
            ram_items[i] <= CountWidth'(Depth));
        a_empty_consistent: assert property (@(posedge clk) disable iff (rst)
            ram_empty[i] == !head_valid[i]);
        a_no_push_full: assert property (@(posedge clk) disable iff (rst)
            (push_valid && (push_fifo_id == FifoIdWidth'(i))) |-> (ram_items[i] != CountWidth'(Depth)));
    end

endmodule

// File: rtl/br_fifo_shared_next_ptr_table.sv
// Shared next-pointer storage: one write port from the push side, one
// asynchronous read port per logical FIFO for head advancement.
module br_fifo_shared_next_ptr_table #(
    parameter int Depth        = 2,
    parameter int NumReadPorts = 1,
    parameter int AddrWidth    = 1
) (
    input  logic                                      clk,
    input  logic                                      wr_valid,
    input  logic [AddrWidth-1:0]                      wr_addr,
    input  logic [AddrWidth-1:0]                      wr_data,
    input  logic [NumReadPorts-1:0][AddrWidth-1:0]    rd_addr,
    output logic [NumReadPorts-1:0][AddrWidth-1:0]    rd_data
);

    logic [Depth-1:0][AddrWidth-1:0] r_ptr;

    // Link storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        for (int d = 0; d < Depth; d++) begin
            if (wr_valid && (wr_addr == AddrWidth'(d))) begin
                r_ptr[d] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        assign rd_data[p] = r_ptr[rd_addr[p]];
    end

endmodule

// File: rtl/br_fifo_shared_linked_list_head_ctrl.sv
// Per-FIFO linked-list head/tail/count tracking over a shared entry pool;
// pushes append to a FIFO's tail, pops advance its head through next_ptr.
module br_fifo_shared_linked_list_head_ctrl
    import br_fifo_shared_linked_list_head_ctrl_pkg::*;
#(
    parameter int NumFifos = 1,
    parameter int Depth    = 2,
    localparam int AddrWidth   = $clog2(Depth),
    localparam int CountWidth  = $clog2(Depth + 1),
    localparam int FifoIdWidth = clamped_clog2(NumFifos)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push_valid,
    input  logic [AddrWidth-1:0]                  push_entry_id,
    input  logic [FifoIdWidth-1:0]                push_fifo_id,
    output logic [NumFifos-1:0]                   head_valid,
    input  logic [NumFifos-1:0]                   head_ready,
    output logic [NumFifos-1:0][AddrWidth-1:0]    head,
    output logic [NumFifos-1:0]                   ram_empty,
    output logic [NumFifos-1:0][CountWidth-1:0]   ram_items
);

    logic [NumFifos-1:0]                 w_push;
    logic [NumFifos-1:0]                 w_pop;
    logic [NumFifos-1:0]                 w_cnt_nz;
    logic [NumFifos-1:0][AddrWidth-1:0]  w_tail;
    logic [NumFifos-1:0][AddrWidth-1:0]  w_head;
    logic [NumFifos-1:0][AddrWidth-1:0]  w_next;
    logic                                w_wr_valid;
    logic [AddrWidth-1:0]                w_wr_addr;

    for (genvar i = 0; i < NumFifos; i++) begin : g_fifo
        logic [AddrWidth-1:0]  r_head;
        logic [AddrWidth-1:0]  r_tail;
        logic [CountWidth-1:0] r_count;

        assign w_push[i]   = push_valid && (push_fifo_id == FifoIdWidth'(i));
        assign w_pop[i]    = head_valid[i] && head_ready[i];
        assign w_cnt_nz[i] = (r_count != {CountWidth{1'b0}});
        assign w_tail[i]   = r_tail;
        assign w_head[i]   = r_head;

        assign head_valid[i] = w_cnt_nz[i];
        assign ram_empty[i]  = !w_cnt_nz[i];
        assign ram_items[i]  = r_count;
        assign head[i]       = r_head;

        // List state: only a pop can move the head off a presented entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_count <= {CountWidth{1'b0}};
                r_head  <= {AddrWidth{1'b0}};
                r_tail  <= {AddrWidth{1'b0}};
            end else begin
                case (head_select(w_push[i], w_pop[i], !w_cnt_nz[i],
                                  r_count == CountWidth'(1)))
                    HEAD_LOAD_PUSH: r_head <= push_entry_id;
                    HEAD_ADVANCE:   r_head <= w_next[i];
                    default:        r_head <= r_head;
                endcase
                if (w_push[i]) begin
                    r_tail <= push_entry_id;
                end else begin
                    r_tail <= r_tail;
                end
                r_count <= r_count + CountWidth'(w_push[i]) - CountWidth'(w_pop[i]);
            end
        end
    end

    // Push decode is one-hot, so an OR-reduction selects the destination tail.
    always_comb begin
        w_wr_valid = 1'b0;
        w_wr_addr  = {AddrWidth{1'b0}};
        for (int i = 0; i < NumFifos; i++) begin
            w_wr_valid = w_wr_valid | (w_push[i] & w_cnt_nz[i]);
            w_wr_addr  = w_wr_addr | ({AddrWidth{w_push[i]}} & w_tail[i]);
        end
    end

    br_fifo_shared_next_ptr_table #(
        .Depth        (Depth),
        .NumReadPorts (NumFifos),
        .AddrWidth    (AddrWidth)
    ) u_next_ptr (
        .clk      (clk),
        .wr_valid (w_wr_valid),
        .wr_addr  (w_wr_addr),
        .wr_data  (push_entry_id),
        .rd_addr  (w_head),
        .rd_data  (w_next)
    );

    br_fifo_shared_linked_list_head_ctrl_chk #(
        .NumFifos    (NumFifos),
        .Depth       (Depth),
        .AddrWidth   (AddrWidth),
        .CountWidth  (CountWidth),
        .FifoIdWidth (FifoIdWidth)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_fifo_id (push_fifo_id),
        .head_valid   (head_valid),
        .head_ready   (head_ready),
        .head         (head),
        .ram_empty    (ram_empty),
        .ram_items    (ram_items)
    );

endmodule
